// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and hazard/forwarding response bundle for hazard_scoreboard
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int STAGES     = 3,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(STAGES + 1);

    // Instruction currently held in ID
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_regS_addr;
    logic [REG_ADDR_W-1:0] id_regT_addr;
    logic                  id_use_regS;
    logic                  id_use_regT;
    logic [REG_ADDR_W-1:0] id_dst_reg;
    logic                  id_use_dst_reg;
    logic                  id_is_load;
    logic                  flush;
    logic                  hlt;

    // Scoreboard results
    logic                  stall;
    logic [SEL_W-1:0]      fwd_selS;
    logic [SEL_W-1:0]      fwd_selT;
    logic [STAGES-1:0]     inflight_valid;
    logic [CNT_W-1:0]      stall_count;

    // Decode side drives the instruction, reads back the hazard decision
    modport master (
        output id_valid, id_regS_addr, id_regT_addr, id_use_regS, id_use_regT,
        output id_dst_reg, id_use_dst_reg, id_is_load, flush, hlt,
        input  stall, fwd_selS, fwd_selT, inflight_valid, stall_count
    );

    // Scoreboard side
    modport slave (
        input  id_valid, id_regS_addr, id_regT_addr, id_use_regS, id_use_regT,
        input  id_dst_reg, id_use_dst_reg, id_is_load, flush, hlt,
        output stall, fwd_selS, fwd_selT, inflight_valid, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination scoreboard with stall and optional forwarding selects (HAZARD_FWD_EN)
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int STAGES     = 3,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   bus
);
    localparam int SEL_W = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Entry 0 is EX, entry STAGES-1 is WB
    logic [STAGES-1:0]                 ent_valid;
    logic [STAGES-1:0][REG_ADDR_W-1:0] ent_dst;
    logic [STAGES-1:0]                 ent_load;
    logic [CNT_W-1:0]                  count_q;

    logic              qual_s;
    logic              qual_t;
    logic [STAGES-1:0] match_s;
    logic [STAGES-1:0] match_t;
    logic              stall;
    logic              insert;
    logic [SEL_W-1:0]  sel_s;
    logic [SEL_W-1:0]  sel_t;

    // Register 0 never carries a hazard, and unused operands are ignored
    assign qual_s = bus.id_valid && bus.id_use_regS && (bus.id_regS_addr != '0);
    assign qual_t = bus.id_valid && bus.id_use_regT && (bus.id_regT_addr != '0);

    // Compare both sources against every tracked entry, WB included
    always_comb begin
        match_s = '0;
        match_t = '0;
        for (int i = 0; i < STAGES; i++) begin
            match_s[i] = qual_s && ent_valid[i] && (ent_dst[i] == bus.id_regS_addr);
            match_t[i] = qual_t && ent_valid[i] && (ent_dst[i] == bus.id_regT_addr);
        end
    end

`ifdef HAZARD_FWD_EN
    logic [SEL_W-1:0] hit_s;
    logic [SEL_W-1:0] hit_t;
    logic             lu_s;
    logic             lu_t;

    // Youngest match wins; a load still in EX cannot forward yet
    always_comb begin
        hit_s = '0;
        hit_t = '0;
        lu_s  = 1'b0;
        lu_t  = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                hit_s = SEL_W'(i + 1);
                lu_s  = (i == 0) && ent_load[0];
            end
            if (match_t[i]) begin
                hit_t = SEL_W'(i + 1);
                lu_t  = (i == 0) && ent_load[0];
            end
        end
        sel_s = lu_s ? '0 : hit_s;
        sel_t = lu_t ? '0 : hit_t;
        stall = lu_s || lu_t;
    end
`else
    logic unused_load;

    // Without forwarding any in-flight writer of a source blocks issue
    always_comb begin
        sel_s = '0;
        sel_t = '0;
        stall = (|match_s) || (|match_t);
    end

    assign unused_load = ^ent_load;
`endif

    // A stalled or flushed instruction enters EX as a bubble
    assign insert = bus.id_valid && bus.id_use_dst_reg && (bus.id_dst_reg != '0)
                    && !stall && !bus.flush;

    // Advance the in-flight window and count stall cycles unless halted
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            ent_dst   <= '0;
            ent_load  <= '0;
            count_q   <= '0;
        end else if (!bus.hlt) begin
            for (int i = 1; i < STAGES; i++) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_dst[i]   <= ent_dst[i-1];
                ent_load[i]  <= ent_load[i-1];
            end
            ent_valid[0] <= insert;
            ent_dst[0]   <= bus.id_dst_reg;
            ent_load[0]  <= insert && bus.id_is_load;
            if (stall && (count_q != CNT_MAX)) begin
                count_q <= count_q + CNT_ONE;
            end
        end
    end

    assign bus.stall          = stall;
    assign bus.fwd_selS       = sel_s;
    assign bus.fwd_selT       = sel_t;
    assign bus.inflight_valid = ent_valid;
    assign bus.stall_count    = count_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the CPU's fixed EX/MEM/WB register-compare stall equation.
- Tracks in-flight destination registers through a configurable number of post-decode stages.
- Drives a registered-state, zero-latency stall to PC_MUX and the pipeline registers.
- Optionally produces per-operand forwarding selects and a load-use-only stall. Sits beside instr_decode.

Parameters:
- REG_ADDR_W, 5, register address width (register 0 is hardwired zero, never a hazard).
- STAGES, 3, in-flight stages tracked after ID (entry 0 = EX, entry STAGES-1 = WB); legal range 1..7.
- CNT_W, 16, width of the saturating stall-cycle counter.
- localparam SEL_W = clog2(STAGES+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_regS_addr  in  REG_ADDR_W  source S address
- id_regT_addr  in  REG_ADDR_W  source T address
- id_use_regS  in  1  instruction reads S
- id_use_regT  in  1  instruction reads T
- id_dst_reg  in  REG_ADDR_W  destination address
- id_use_dst_reg  in  1  instruction writes destination
- id_is_load  in  1  destination written from memory (result available only after MEM)
- flush  in  1  squash the instruction in ID
- hlt  in  1  freeze scoreboard
- stall  out  1  hold IF/ID, insert bubble into EX
- fwd_selS  out  SEL_W  forward source for S (0 = register file, k = entry k-1)
- fwd_selT  out  SEL_W  forward source for T
- inflight_valid  out  STAGES  per-entry valid bits
- stall_count  out  CNT_W  stall cycles observed, saturating

Behaviour:
- State: STAGES entries {valid, dst[REG_ADDR_W], is_load}.
- Reset: all entries invalid and stall_count = 0, so stall = 0, fwd_selS/T = 0, inflight_valid = 0.
  - rst dominates hlt and flush.
  - Reset mid-operation discards all tracked writes.
- Source match, per source X:
  - Qualifying condition: id_valid & id_use_regX & addrX != 0.
  - Entry i matches if valid[i] & dst[i] == addrX.
- stall (no FWD):
  - Combinational from entry state plus ID inputs; zero-cycle latency.
  - stall = 1 if either qualifying source matches any entry, all STAGES compared (WB included; the register file has no write-through).
  - Matches in several entries give the same stall = 1.
  - S and T naming the same register behave the same as one match.
- Update each clk, when rst = 0 and hlt = 0:
  - entry[i] <= entry[i-1] for i >= 1; entry STAGES-1 retires.
  - entry[0] loads {1, id_dst_reg, id_is_load} iff id_valid & id_use_dst_reg & id_dst_reg != 0 & !stall & !flush. Otherwise entry[0] loads a bubble (valid = 0).
  - A stall therefore drains older entries while ID holds; the stall drops once the matching entry retires.
- hlt = 1: entries and stall_count hold. stall/fwd outputs are still computed from the held state.
- flush with stall: flush wins for insertion (bubble). The stall output still reflects the comparison.
- stall_count increments on each clk with stall & !hlt & !rst and saturates at all-ones (no wrap).
- An instruction whose dst equals its own source tracks normally; there is no self-hazard.

Optional Feature:
- Macro: HAZARD_FWD_EN
- Defined:
  - For each qualifying source, the youngest matching entry (lowest index i) wins.
  - If that entry is i = 0 and its is_load = 1: stall = 1 and fwd_sel = 0 (load-use).
  - Otherwise: no stall from that source, and fwd_selX = i+1.
  - No match: fwd_selX = 0.
  - stall is the OR over S and T.
- Undefined: fwd_selS/T are tied to 0, and the stall rule above (stall on any match) applies.

Test Plan:
- Reset then idle → stall = 0, inflight_valid = 000, stall_count = 0.
- Back-to-back RAW, no FWD:
  - Stimulus: issue dst = r3, then next instruction reads S = r3.
  - Expected: stall = 1 for exactly 3 cycles, then the instruction issues; stall_count = 3.
- r0 and disabled operands:
  - Stimulus: dst = r0 write followed by a read of r0; separately, use_regT = 0 with regT_addr matching an in-flight dst.
  - Expected: stall = 0 in both cases; no entry allocated for the r0 write.
- hlt and saturation:
  - Stimulus: hlt asserted during a stall for 5 cycles.
  - Expected: entries frozen, stall_count unchanged.
  - Also: preload the counter near all-ones and stall; count holds at 0xFFFF.
- FWD enabled:
  - Stimulus: ALU writes r5, then r5 read.
  - Expected: fwd_selS = 1, stall = 0. Read one instruction later: fwd_selS = 2.
  - Stimulus: load to r7, then immediate read of r7.
  - Expected: stall = 1 for one cycle, then fwd_selS = 2.
- Flush and reset mid-operation:
  - Stimulus: flush with ID dst = r4.
  - Expected: r4 never appears in inflight entries.
  - Stimulus: rst with 3 valid entries.
  - Expected: next cycle inflight_valid = 000, stall = 0.
